bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, BRAM data width in bits.
REQ-002 Parameter AW, default 8, BRAM address width in bits.
REQ-003 Parameter N, default 2, number of requesters (legal range 2..4).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester access request; bit i belongs to requester i.
REQ-007 lock  input  N  per-requester hold request, to keep ownership across back-to-back accesses.
REQ-008 addr  input  N*AW  per-requester address; slice i is [i*AW +: AW].
REQ-009 din  input  N*WIDTH  per-requester write data; slice i is [i*WIDTH +: WIDTH].
REQ-010 we  input  N  per-requester write enable, qualified by req.
REQ-011 gnt  output  N  one-hot grant; the access is issued to BRAM in the same cycle.
REQ-012 rvalid  output  N  one-hot read-data-valid strobe.
REQ-013 rdata  output  WIDTH  read data, shared by all requesters and qualified by rvalid.
REQ-014 mem_addr  output  AW  BRAM address.
REQ-015 mem_din  output  WIDTH  BRAM write data.
REQ-016 mem_we  output  1  BRAM write enable.
REQ-017 mem_dout  input  WIDTH  BRAM read data, registered in the BRAM, 1-cycle latency.

Function
REQ-018 gnt shall be combinational from req, lock, owner state and priority pointer, with at most one bit set per cycle.
REQ-019 With no req bit set, gnt = 0, mem_we = 0, mem_addr = 0 and mem_din = 0.
REQ-020 With gnt[i] set, mem_addr, mem_din and mem_we shall equal addr slice i, din slice i and we[i].
REQ-021 Arbitration shall be round-robin: search starts at index ptr and wraps modulo N; the first set req bit wins.
REQ-022 After a grant to i without a lock hold, ptr shall update to (i+1) mod N at the clock edge; wrap from N-1 goes to 0.
REQ-023 Lock state: register owner_valid plus owner index; when the granted requester has lock[i]=1, owner_valid shall be set with owner=i.
REQ-024 While owner_valid and req[owner]=1, gnt shall go to owner regardless of other requests, and ptr shall not change.
REQ-025 Ownership release: owner_valid shall clear on any cycle where req[owner]=0 or lock[owner]=0, with ptr set to (owner+1) mod N.
REQ-026 On a release caused by req[owner]=0, normal round-robin arbitration shall apply in that same cycle.
REQ-027 rvalid[i] shall assert exactly one cycle after a cycle where gnt[i]=1 and we[i]=0, and shall stay low otherwise.
REQ-028 A granted write (we[i]=1) shall produce no rvalid.
REQ-029 rdata shall equal mem_dout in every cycle where any rvalid bit is high; otherwise it is don't-care.
REQ-030 Back-to-back grants shall be supported at one access per cycle with no bubble, including read-after-write to the same address (BRAM read-first or write-first behaviour passes through unchanged).
REQ-031 A requester shall hold req, addr, din and we stable until it sees gnt; the arbiter needs no other handshake.
REQ-032 Simultaneous requests: exactly one grant per cycle; the losers stay pending and are not dropped.
REQ-033 Starvation bound: without locks, any requester with req held shall be granted within N cycles.

Reset
REQ-034 While rst=1: gnt = 0, rvalid = 0, mem_we = 0, ptr = 0, owner_valid = 0; requests are ignored.
REQ-035 A read granted in the cycle before rst asserts shall not produce rvalid during reset.
REQ-036 In the first cycle after rst deasserts, requester 0 has highest priority.

Verification
REQ-037 N=2, req=11 held, no locks, both reads -> gnt sequence 01,10,01,10; each rvalid one cycle after its gnt with rdata = BRAM content.
REQ-038 Requester 0 writes 0xA5 to addr 0x10, then requester 1 reads 0x10 -> rvalid[1] asserts with rdata = 0xA5; no rvalid for the write.
REQ-039 Requester 1 with lock=1 and req held for 5 cycles while requester 0 requests -> gnt = 10 for 5 cycles, then gnt = 01 in the cycle req[1] drops.
REQ-040 N=4, req=1111 held, no locks -> gnt cycles 0001,0010,0100,1000,0001; no requester waits more than 4 cycles.
REQ-041 rst asserted mid-lock and mid-read -> gnt = 0 and rvalid = 0 throughout reset; after release, req=0011 -> gnt = 0001.
REQ-042 Idle (req=0) for 3 cycles -> mem_we = 0 and mem_addr = 0 in every cycle; ptr unchanged.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares a single BRAM port between N requesters (N = 2..4). Grants are
// combinational, so the winning access goes out to the BRAM in the same
// cycle it is granted. The search is round-robin and starts at a priority
// pointer. A requester can hold ownership across back-to-back accesses by
// keeping lock high. Read data comes back one cycle later on a shared bus,
// and a one-hot rvalid strobe names the requester it belongs to.
//
// Parameters
//   WIDTH    BRAM data width in bits
//   AW       BRAM address width in bits
//   N        number of requesters (2..4)
//
// Ports
//   clk      clock; all state changes on the rising edge
//   rst      synchronous, active-high reset
//   req      per-requester access request (bit i = requester i)
//   lock     per-requester ownership hold
//   addr     per-requester address, slice i = [i*AW +: AW]
//   din      per-requester write data, slice i = [i*WIDTH +: WIDTH]
//   we       per-requester write enable, qualified by req
//   gnt      one-hot grant (the access is issued this cycle)
//   rvalid   one-hot read-data-valid, one cycle after a granted read
//   rdata    shared read data, qualified by rvalid
//   mem_addr BRAM address
//   mem_din  BRAM write data
//   mem_we   BRAM write enable
//   mem_dout BRAM read data (registered inside the BRAM, 1-cycle latency)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 8,
    parameter int N     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*AW-1:0]      addr,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [N-1:0]         we,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         rvalid,
    output logic [WIDTH-1:0]     rdata,
    output logic [AW-1:0]        mem_addr,
    output logic [WIDTH-1:0]     mem_din,
    output logic                 mem_we,
    input  logic [WIDTH-1:0]     mem_dout
);

    localparam int PW = $clog2(N);

    // Arbitration state
    logic [PW-1:0] ptr;
    logic          owner_valid;
    logic [PW-1:0] owner;

    logic [PW-1:0] ptr_nxt;
    logic          owner_valid_nxt;
    logic [PW-1:0] owner_nxt;

    // Grant decision for the current cycle
    logic          any_gnt_p0;
    logic [PW-1:0] gnt_idx_p0;
    logic          hold_p0;

    // Read strobe travelling alongside the BRAM read latency
    logic [N-1:0]  rd_vld_p1;

    // Index increment modulo N.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (i == PW'(N - 1)) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    // ---- Stage p0: grant selection and BRAM request mux -------------------
    always_comb begin
        int j;
        j          = 0;
        any_gnt_p0 = 1'b0;
        gnt_idx_p0 = '0;

        // An owner that is still requesting wins outright, even in the
        // cycle it drops lock (that access is its last one).
        hold_p0 = owner_valid && req[owner];

        if (hold_p0) begin
            any_gnt_p0 = 1'b1;
            gnt_idx_p0 = owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!any_gnt_p0 && req[j]) begin
                    any_gnt_p0 = 1'b1;
                    gnt_idx_p0 = PW'(j);
                end
            end
        end

        // Requests are ignored while in reset.
        if (rst) begin
            any_gnt_p0 = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (any_gnt_p0) begin
            gnt[gnt_idx_p0] = 1'b1;
            mem_addr        = addr[gnt_idx_p0*AW +: AW];
            mem_din         = din[gnt_idx_p0*WIDTH +: WIDTH];
            mem_we          = we[gnt_idx_p0];
        end
    end

    // Next pointer / ownership.
    always_comb begin
        ptr_nxt         = ptr;
        owner_valid_nxt = owner_valid;
        owner_nxt       = owner;

        if (owner_valid) begin
            if (req[owner] && lock[owner]) begin
                // Ownership continues; pointer frozen.
                owner_valid_nxt = 1'b1;
            end else begin
                owner_valid_nxt = 1'b0;
                ptr_nxt         = wrap_inc(owner);
                // When the owner simply stopped requesting, this cycle was
                // arbitrated normally, so the new winner updates the state.
                if (!req[owner] && any_gnt_p0) begin
                    if (lock[gnt_idx_p0]) begin
                        owner_valid_nxt = 1'b1;
                        owner_nxt       = gnt_idx_p0;
                        ptr_nxt         = ptr;
                    end else begin
                        ptr_nxt = wrap_inc(gnt_idx_p0);
                    end
                end
            end
        end else if (any_gnt_p0) begin
            if (lock[gnt_idx_p0]) begin
                // Capturing ownership leaves the pointer untouched; it moves
                // past the owner on release.
                owner_valid_nxt = 1'b1;
                owner_nxt       = gnt_idx_p0;
            end else begin
                ptr_nxt = wrap_inc(gnt_idx_p0);
            end
        end
    end

    // ---- Stage p0 -> p1: state register and read-valid pipeline -----------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            owner_valid <= 1'b0;
            owner       <= '0;
            rd_vld_p1   <= '0;
        end else begin
            ptr         <= ptr_nxt;
            owner_valid <= owner_valid_nxt;
            owner       <= owner_nxt;
            rd_vld_p1   <= gnt & ~we;
        end
    end

    // ---- Stage p1: read return ----------------------------------------------
    // A read granted just before reset would otherwise strobe during the
    // first reset cycle, so the strobe is masked by rst directly.
    assign rvalid = rd_vld_p1 & ~{N{rst}};
    assign rdata  = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter with an N=2 instance and an N=4
// instance, each attached to a small registered-read BRAM model. Expected
// read data is queued when a read grant is expected and compared when the
// strobe is due.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    always #5 clk = ~clk;

    // ---------------- N = 2 instance ----------------
    logic [1:0]  req2, lock2, we2, gnt2, rvalid2;
    logic [15:0] addr2, din2;
    logic [7:0]  rdata2, mem_addr2, mem_din2, mem_dout2;
    logic        mem_we2;

    bram_port_arbiter #(.WIDTH(8), .AW(8), .N(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req2),
        .lock     (lock2),
        .addr     (addr2),
        .din      (din2),
        .we       (we2),
        .gnt      (gnt2),
        .rvalid   (rvalid2),
        .rdata    (rdata2),
        .mem_addr (mem_addr2),
        .mem_din  (mem_din2),
        .mem_we   (mem_we2),
        .mem_dout (mem_dout2)
    );

    // ---------------- N = 4 instance ----------------
    logic [3:0]  req4, lock4, we4, gnt4, rvalid4;
    logic [31:0] addr4, din4;
    logic [7:0]  rdata4, mem_addr4, mem_din4, mem_dout4;
    logic        mem_we4;

    bram_port_arbiter #(.WIDTH(8), .AW(8), .N(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .req      (req4),
        .lock     (lock4),
        .addr     (addr4),
        .din      (din4),
        .we       (we4),
        .gnt      (gnt4),
        .rvalid   (rvalid4),
        .rdata    (rdata4),
        .mem_addr (mem_addr4),
        .mem_din  (mem_din4),
        .mem_we   (mem_we4),
        .mem_dout (mem_dout4)
    );

    // ---------------- BRAM models (read-first, 1-cycle read) ----------------
    logic [7:0] bram2 [256];
    logic [7:0] bram4 [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) bram2[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_we2) begin
            bram2[mem_addr2] <= mem_din2;
        end
        mem_dout2 <= bram2[mem_addr2];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) bram4[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_we4) begin
            bram4[mem_addr4] <= mem_din4;
        end
        mem_dout4 <= bram4[mem_addr4];
    end

    // ---------------- Scoreboard / bookkeeping ----------------
    typedef struct {
        int         cyc;
        logic [1:0] rv;
        logic [7:0] data;
    } exp_t;

    exp_t       sb2[$];
    logic [7:0] ref_mem [256];
    int         checks;
    int         errors;
    int         cyc_n;
    logic [3:0] prev_eg4;
    logic [7:0] prev_d4;
    int         wait4  [4];
    int         maxw4  [4];

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the N=2 instance: inputs are already driven.
    task automatic step2(input string tag, input logic [1:0] eg, input bit no_rv);
        int         gi;
        logic [7:0] ga;
        logic [7:0] gd;
        exp_t       e;
        gi = eg[1] ? 1 : 0;
        ga = addr2[gi*8 +: 8];
        gd = din2[gi*8 +: 8];
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt2), 32'(eg));
        if (eg != 2'b00) begin
            chk({tag, ".mem_addr"}, 32'(mem_addr2), 32'(ga));
            chk({tag, ".mem_din"},  32'(mem_din2),  32'(gd));
            chk({tag, ".mem_we"},   32'(mem_we2),   32'(we2[gi]));
        end else begin
            chk({tag, ".mem_addr"}, 32'(mem_addr2), 32'h0);
            chk({tag, ".mem_din"},  32'(mem_din2),  32'h0);
            chk({tag, ".mem_we"},   32'(mem_we2),   32'h0);
        end
        if (sb2.size() > 0 && sb2[0].cyc == cyc_n) begin
            e = sb2.pop_front();
            chk({tag, ".rvalid"}, 32'(rvalid2), 32'(e.rv));
            chk({tag, ".rdata"},  32'(rdata2),  32'(e.data));
        end else begin
            chk({tag, ".rvalid"}, 32'(rvalid2), 32'h0);
        end
        if (eg != 2'b00) begin
            if (we2[gi]) begin
                ref_mem[ga] = gd;
            end else if (!no_rv) begin
                sb2.push_back('{cyc_n + 1, eg, ref_mem[ga]});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // One cycle of the N=4 instance (reads only).
    task automatic step4(input string tag, input logic [3:0] eg);
        @(negedge clk);
        chk({tag, ".gnt4"},    32'(gnt4),    32'(eg));
        chk({tag, ".rvalid4"}, 32'(rvalid4), 32'(prev_eg4));
        if (prev_eg4 != 4'b0000) begin
            chk({tag, ".rdata4"}, 32'(rdata4), 32'(prev_d4));
        end
        for (int i = 0; i < 4; i++) begin
            if (gnt4[i]) begin
                wait4[i] = 0;
            end else if (req4[i]) begin
                wait4[i]++;
                if (wait4[i] > maxw4[i]) maxw4[i] = wait4[i];
            end
        end
        prev_eg4 = eg;
        prev_d4  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) prev_d4 = pat(addr4[i*8 +: 8]);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc_n    = 0;
        prev_eg4 = 4'b0000;
        prev_d4  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wait4[i] = 0;
            maxw4[i] = 0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        rst     = 1'b1;
        mem_clr = 1'b1;
        req2 = '0; lock2 = '0; we2 = '0; addr2 = '0; din2 = '0;
        req4 = '0; lock4 = '0; we4 = '0; addr4 = '0; din4 = '0;
        @(posedge clk);
        #1;
        cyc_n++;

        // Reset ignores requests
        req2  = 2'b11;
        addr2 = {8'h07, 8'h03};
        step2("rst_a", 2'b00, 0);
        step2("rst_b", 2'b00, 0);
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Round-robin reads, both requesting
        step2("rr0", 2'b01, 0);
        step2("rr1", 2'b10, 0);
        step2("rr2", 2'b01, 0);
        step2("rr3", 2'b10, 0);
        req2 = 2'b01;
        step2("rr4", 2'b01, 0);        // pointer now at 1

        // Idle: bus quiet, pointer kept
        req2 = 2'b00;
        step2("idle0", 2'b00, 0);
        step2("idle1", 2'b00, 0);
        step2("idle2", 2'b00, 0);
        req2 = 2'b11;
        step2("idle_ptr", 2'b10, 0);   // pointer back to 0

        // Write then read the same address back to back
        req2  = 2'b01;
        we2   = 2'b01;
        addr2 = {8'h00, 8'h10};
        din2  = {8'h00, 8'hA5};
        step2("wr", 2'b01, 0);
        req2  = 2'b10;
        we2   = 2'b00;
        addr2 = {8'h10, 8'h10};
        step2("raw", 2'b10, 0);
        req2  = 2'b00;
        step2("raw_rv", 2'b00, 0);

        // Requester 1 locks for five accesses while requester 0 waits
        addr2 = {8'h20, 8'h21};
        req2  = 2'b10;
        lock2 = 2'b10;
        step2("lk0", 2'b10, 0);
        req2  = 2'b11;
        step2("lk1", 2'b10, 0);
        step2("lk2", 2'b10, 0);
        step2("lk3", 2'b10, 0);
        step2("lk4", 2'b10, 0);
        req2  = 2'b01;
        lock2 = 2'b00;
        step2("lk_rel", 2'b01, 0);

        // Release by dropping lock while still requesting
        req2  = 2'b10;
        lock2 = 2'b10;
        step2("ul0", 2'b10, 0);
        req2  = 2'b11;
        lock2 = 2'b00;
        step2("ul1", 2'b10, 0);
        step2("ul2", 2'b01, 0);

        // Reset during a lock with a read in flight
        req2  = 2'b10;
        lock2 = 2'b10;
        step2("pre_rst", 2'b10, 1);
        rst   = 1'b1;
        req2  = 2'b11;
        step2("rst_c", 2'b00, 0);
        step2("rst_d", 2'b00, 0);
        rst   = 1'b0;
        lock2 = 2'b00;
        step2("post_rst", 2'b01, 0);
        req2  = 2'b00;
        step2("post_idle", 2'b00, 0);
        chk("sb2_drain", 32'(sb2.size()), 32'h0);

        // Four requesters, all holding reads
        addr4 = {8'h33, 8'h32, 8'h31, 8'h30};
        req4  = 4'b1111;
        step4("n4_0", 4'b0001);
        step4("n4_1", 4'b0010);
        step4("n4_2", 4'b0100);
        step4("n4_3", 4'b1000);
        step4("n4_4", 4'b0001);
        req4  = 4'b0000;
        step4("n4_idle", 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("n4_wait%0d_le3", i), 32'(maxw4[i] <= 3), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
